// File: rtl/mp_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mp_add_pkg
// Brief   : Shared state encoding and byte-width constant for mp_add_seq.
// Revision: 1.0
// ============================================================================
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cla8_slice.sv
`default_nettype none
// ============================================================================
// Module  : cla8_slice
// Brief   : Combinational 8-bit carry-lookahead adder slice.
// Revision: 1.0
// ============================================================================
module cla8_slice
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              prop;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of generate terms gated by the propagate chain above them.
    always_comb begin
        c    = '0;
        prop = 1'b1;
        c[0] = ci;
        for (int i = 0; i < BYTE_W; i++) begin
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prop);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (ci & prop);
        end
    end

    assign s  = p ^ c[BYTE_W-1:0];
    assign co = c[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : mp_add_seq
// Brief   : Byte-serial multi-precision add/subtract around one CLA slice.
//           Optional signed-overflow output enabled by MP_ADD_OVF_EN.
// Revision: 1.0
// ============================================================================
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
`ifdef MP_ADD_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int              KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int              W      = BYTE_W * NBYTES;
    localparam logic [KW-1:0]   K_LAST = KW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
`ifdef MP_ADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] slice_a;
    logic [BYTE_W-1:0] slice_b;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_co;

    assign slice_a = a_q[k_q*BYTE_W +: BYTE_W];
    assign slice_b = b_q[k_q*BYTE_W +: BYTE_W];

    cla8_slice u_cla8_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MP_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[k_q*BYTE_W +: BYTE_W] = slice_s;
                carry_d                     = slice_co;
                // k parks on the last byte; it is only cleared by acceptance or reset.
                if (k_q == K_LAST) begin
                    cout_d  = slice_co;
`ifdef MP_ADD_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_s[BYTE_W-1] != a_q[W-1]);
`endif
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef MP_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_mp_add_seq
// Brief   : Directed self-checking bench for mp_add_seq (NBYTES = 4).
// Revision: 1.0
// ============================================================================
module tb_mp_add_seq;

    localparam int NBYTES = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef MP_ADD_OVF_EN
    logic        ovf;
`endif

    int n_cmp;
    int n_err;

    mp_add_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef MP_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, verify latency/result, then drain with a handshake.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [31:0] esum, input logic ecout);
        int lat;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = ~tcin; sub = ~tsub;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(NBYTES + 1));
        check({tag, "/sum"}, 64'(sum), 64'(esum));
        check({tag, "/cout"}, 64'(cout), 64'(ecout));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/drained"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst/in_ready", 64'(in_ready), 64'd1);
        check("rst/out_valid", 64'(out_valid), 64'd0);
        check("rst/sum", 64'(sum), 64'd0);
        check("rst/cout", 64'(cout), 64'd0);

        run_op("ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
        run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1);
        run_op("sub_lt", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_op("sub_gt", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
`ifdef MP_ADD_OVF_EN
        run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
        check("ovf_add/ovf", 64'(ovf), 64'd1);
        run_op("ovf_none", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        check("ovf_none/ovf", 64'(ovf), 64'd0);
`endif

        // Backpressure: second operand set waits on the source while DONE is stalled.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h8000_0000; b = 32'h8000_0000;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp/latency", 64'(lat), 64'(NBYTES + 1));
        for (int i = 0; i < 10; i++) begin
            check("bp/out_valid", 64'(out_valid), 64'd1);
            check("bp/sum", 64'(sum), 64'h2345_6789);
            check("bp/in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp/idle_after_hs", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/second_taken", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp2/latency", 64'(lat), 64'(NBYTES + 1));
        check("bp2/sum", 64'(sum), 64'h0000_0000);
        check("bp2/cout", 64'(cout), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Abort with reset while byte 2 is current.
        a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort/in_ready", 64'(in_ready), 64'd1);
        check("abort/out_valid", 64'(out_valid), 64'd0);
        check("abort/sum", 64'(sum), 64'd0);
        check("abort/cout", 64'(cout), 64'd0);
        run_op("post_abort", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
        run_op("plain", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
